lfsr_rand_sched: RTL

//  Shares one 16-bit Galois LFSR pseudo-random source between NREQ requesters.

---
 rtl/lfsr_rand_sched.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/lfsr_rand_sched.sv
`default_nettype none
// =============================================================================
// lfsr_rand_sched : round-robin server of 16-bit Galois LFSR words to NREQ users.
// Optional feature macro LFSR_SCHED_STATS_EN adds the words_served counter port.
// Revision 1.0
// =============================================================================
module lfsr_rand_sched #(
  parameter int          NREQ           = 4,
  parameter int          STEPS_PER_WORD = 16,
  parameter logic [15:0] SEED_DEFAULT   = 16'hACE1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            seed_load,
  input  logic [15:0]     seed_in,
  output logic [NREQ-1:0] gnt,
  output logic            rnd_valid,
  output logic [15:0]     rnd_data,
`ifdef LFSR_SCHED_STATS_EN
  output logic [15:0]     words_served,
`endif
  output logic            busy
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    STEP    = 2'd1,
    DELIVER = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [15:0]       lfsr_q, lfsr_d;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [15:0]       step_cnt_q, step_cnt_d;
  logic              seed_pend_q, seed_pend_d;
  logic [15:0]       seed_hold_q, seed_hold_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic              rnd_valid_q, rnd_valid_d;
  logic [15:0]       rnd_data_q, rnd_data_d;
  logic [15:0]       words_q, words_d;

  logic [IDX_W-1:0]  pick_idx;
  logic              pick_found;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[0], s[15], s[14] ^ s[0], s[13] ^ s[0], s[12], s[11] ^ s[0], s[10:1]};
  endfunction

  // A zero state would lock the LFSR, so it is never allowed in.
  function automatic logic [15:0] seed_fix(input logic [15:0] s);
    return (s == 16'h0000) ? SEED_DEFAULT : s;
  endfunction

  // Scan downward so the requester closest to rr_ptr wins.
  always_comb begin
    int j;
    j          = 0;
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = (int'(rr_ptr_q) + k) % NREQ;
      if (req[j]) begin
        pick_found = 1'b1;
        pick_idx   = IDX_W'(j);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    rr_ptr_d    = rr_ptr_q;
    idx_d       = idx_q;
    step_cnt_d  = step_cnt_q;
    seed_pend_d = seed_pend_q;
    seed_hold_d = seed_hold_q;
    gnt_d       = '0;
    rnd_valid_d = 1'b0;
    rnd_data_d  = rnd_data_q;
    words_d     = words_q;

    case (state_q)
      IDLE: begin
        if (seed_load) begin
          lfsr_d      = seed_fix(seed_in);
          seed_pend_d = 1'b0;
          words_d     = '0;
        end else if (seed_pend_q) begin
          lfsr_d      = seed_fix(seed_hold_q);
          seed_pend_d = 1'b0;
          words_d     = '0;
        end else if (pick_found) begin
          idx_d      = pick_idx;
          step_cnt_d = 16'(STEPS_PER_WORD - 1);
          state_d    = STEP;
        end
      end
      STEP: begin
        lfsr_d = lfsr_step(lfsr_q);
        if (step_cnt_q == 16'd0) begin
          state_d = DELIVER;
        end else begin
          step_cnt_d = step_cnt_q - 16'd1;
        end
      end
      DELIVER: begin
        rnd_valid_d = 1'b1;
        gnt_d       = {{(NREQ-1){1'b0}}, 1'b1} << idx_q;
        rnd_data_d  = lfsr_q;
        rr_ptr_d    = (idx_q == IDX_W'(NREQ - 1)) ? '0 : idx_q + IDX_W'(1);
        words_d     = words_q + 16'd1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Seeds arriving while busy wait for the next IDLE cycle; the last one wins.
    if (state_q != IDLE && seed_load) begin
      seed_hold_d = seed_in;
      seed_pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      lfsr_q      <= SEED_DEFAULT;
      rr_ptr_q    <= '0;
      idx_q       <= '0;
      step_cnt_q  <= '0;
      seed_pend_q <= 1'b0;
      seed_hold_q <= '0;
      gnt_q       <= '0;
      rnd_valid_q <= 1'b0;
      rnd_data_q  <= '0;
      words_q     <= '0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      rr_ptr_q    <= rr_ptr_d;
      idx_q       <= idx_d;
      step_cnt_q  <= step_cnt_d;
      seed_pend_q <= seed_pend_d;
      seed_hold_q <= seed_hold_d;
      gnt_q       <= gnt_d;
      rnd_valid_q <= rnd_valid_d;
      rnd_data_q  <= rnd_data_d;
      words_q     <= words_d;
    end
  end

  assign gnt       = gnt_q;
  assign rnd_valid = rnd_valid_q;
  assign rnd_data  = rnd_data_q;
  assign busy      = (state_q != IDLE);

`ifdef LFSR_SCHED_STATS_EN
  assign words_served = words_q;
`else
  logic unused_words;
  assign unused_words = ^words_q;
`endif

endmodule
`default_nettype wire
